// File: rtl/sprite_rom_reader.sv
// Sprite ROM read initiator: maps draw coordinates to a ROM address and selects the
// returned palette index through a fixed 3-cycle pipeline that absorbs the ROM read latency.
module sprite_rom_reader #(
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int ADDR_W      = 10,
    parameter int IDX_W       = 4,
    parameter int TRANSP_IDX  = 0,
    parameter int ANIM_PERIOD = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              pixel_valid,
    input  logic              frame_tick,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [1:0]        dir,
    input  logic              moving,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        q_down,
    input  logic [3:0]        q_up,
    input  logic [3:0]        q_left,
    input  logic [3:0]        q_right1,
    input  logic [2:0]        q_right2,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_opaque,
    output logic [9:0]        pix_x,
    output logic [9:0]        pix_y
);

    localparam int CNT_W = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_PERIOD - 1);
    localparam logic [10:0] SPR_W11 = 11'(SPR_W);
    localparam logic [10:0] SPR_H11 = 11'(SPR_H);

    typedef enum logic [2:0] {
        SEL_DOWN, SEL_UP, SEL_LEFT, SEL_R1, SEL_R2
    } sel_t;

    typedef struct packed {
        logic       in_box;
        sel_t       sel;
        logic [9:0] x;
        logic [9:0] y;
    } stage_t;

    logic [1:0]       dir_q;
    logic             phase;
    logic [CNT_W-1:0] cnt;
    sel_t             sel;
    logic [10:0]      rx, ry;
    logic             in_box;
    stage_t           s1, s2;
    logic [3:0]       q_sel;
    logic [IDX_W-1:0] idx;
    logic             opaque;

    // Direction and animation phase only move on frame boundaries.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dir_q <= 2'd0;
            phase <= 1'b0;
            cnt   <= '0;
        end else if (frame_tick) begin
            dir_q <= dir;
            if (!moving) begin
                phase <= 1'b0;
                cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
                phase <= ~phase;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sel = SEL_DOWN;
        case (dir_q)
            2'd0: sel = SEL_DOWN;
            2'd1: sel = SEL_UP;
            2'd2: sel = SEL_LEFT;
            2'd3: sel = phase ? SEL_R2 : SEL_R1;
            default: sel = SEL_DOWN;
        endcase
    end

    // 11-bit differences: a sprite to the right/below wraps large and fails the compare.
    assign rx     = {1'b0, draw_x} - {1'b0, sprite_x};
    assign ry     = {1'b0, draw_y} - {1'b0, sprite_y};
    assign in_box = pixel_valid && (rx < SPR_W11) && (ry < SPR_H11);

    always_comb begin
        q_sel = q_down;
        case (s2.sel)
            SEL_DOWN: q_sel = q_down;
            SEL_UP:   q_sel = q_up;
            SEL_LEFT: q_sel = q_left;
            SEL_R1:   q_sel = q_right1;
            SEL_R2:   q_sel = {1'b0, q_right2};
            default:  q_sel = q_down;
        endcase
    end

    assign idx    = IDX_W'(q_sel);
    assign opaque = s2.in_box && (idx != IDX_W'(TRANSP_IDX));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rom_addr   <= '0;
            s1         <= '0;
            s2         <= '0;
            pix_idx    <= '0;
            pix_opaque <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
        end else begin
            rom_addr   <= in_box ? ADDR_W'(32'(ry) * SPR_W + 32'(rx)) : '0;
            s1         <= '{in_box: in_box, sel: sel, x: draw_x, y: draw_y};
            s2         <= s1;
            pix_opaque <= opaque;
            pix_idx    <= opaque ? idx : '0;
            pix_x      <= s2.x;
            pix_y      <= s2.y;
        end
    end

endmodule
